// File: rtl/display_mux_ctrl_if.sv
// Switch inputs and multiplexed display drive shared by the dual-digit display controller.
// The master side owns the switch pins; the slave side is the controller that drives the display.
interface display_mux_ctrl_if;
    logic [3:0] onboard_sw;
    logic [3:0] bboard_sw;
    logic [3:0] hex_sel;
    logic [1:0] anode_n;
    logic       active_digit;

    modport master (
        output onboard_sw,
        output bboard_sw,
        input  hex_sel,
        input  anode_n,
        input  active_digit
    );

    modport slave (
        input  onboard_sw,
        input  bboard_sw,
        output hex_sel,
        output anode_n,
        output active_digit
    );
endinterface

// File: rtl/display_mux_ctrl.sv
// Time-multiplexes one seven-segment decoder across two digits, with optional blanking
// gaps between slots. Every output is registered and changes only on a slot boundary.
module display_mux_ctrl #(
    parameter int unsigned REFRESH_DIV  = 24000,
    parameter int unsigned BLANK_CYCLES = 480
) (
    input logic               clk,
    input logic               reset,
    display_mux_ctrl_if.slave disp_io
);

    localparam int unsigned MaxLen = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxLen + 1);

    localparam logic [CntW-1:0] RefreshLen = CntW'(REFRESH_DIV);
    localparam logic [CntW-1:0] BlankLen   = CntW'(BLANK_CYCLES);
    localparam logic [CntW-1:0] CntOne     = CntW'(1);
    localparam bit              HasBlank   = (BLANK_CYCLES != 0);

    localparam logic [1:0] StBlank0 = 2'd0;
    localparam logic [1:0] StDigit0 = 2'd1;
    localparam logic [1:0] StBlank1 = 2'd2;
    localparam logic [1:0] StDigit1 = 2'd3;

    localparam logic [1:0]      RstState = HasBlank ? StBlank0 : StDigit0;
    localparam logic [CntW-1:0] RstCnt   = HasBlank ? BlankLen : RefreshLen;
    localparam logic [1:0]      RstAnode = HasBlank ? 2'b11 : 2'b10;

    logic [3:0]      ob_meta_q, ob_sync_q;
    logic [3:0]      bb_meta_q, bb_sync_q;
    logic [1:0]      state_q, state_d, state_nxt;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            armed_q;
    logic [3:0]      hex_q, hex_d;
    logic [1:0]      anode_q, anode_d;
    logic            digit_q, digit_d;
    logic            advance;

    // The first edge after reset holds the counter, so the initial slot spans its full
    // length counted from cycle 0.
    assign advance = armed_q && (cnt_q == CntOne);

    always_comb begin
        state_nxt = StDigit0;
        case (state_q)
            StBlank0: state_nxt = StDigit0;
            StDigit0: state_nxt = HasBlank ? StBlank1 : StDigit1;
            StBlank1: state_nxt = StDigit1;
            default:  state_nxt = HasBlank ? StBlank0 : StDigit0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        anode_d = anode_q;
        digit_d = digit_q;
        if (advance) begin
            state_d = state_nxt;
            case (state_nxt)
                StDigit0: begin
                    cnt_d   = RefreshLen;
                    hex_d   = ~ob_sync_q;
                    anode_d = 2'b10;
                    digit_d = 1'b0;
                end
                StDigit1: begin
                    cnt_d   = RefreshLen;
                    hex_d   = ~bb_sync_q;
                    anode_d = 2'b01;
                    digit_d = 1'b1;
                end
                default: begin
                    cnt_d   = BlankLen;
                    anode_d = 2'b11;
                end
            endcase
        end else if (armed_q) begin
            cnt_d = cnt_q - CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ob_meta_q <= 4'hF;
            ob_sync_q <= 4'hF;
            bb_meta_q <= 4'hF;
            bb_sync_q <= 4'hF;
            state_q   <= RstState;
            cnt_q     <= RstCnt;
            armed_q   <= 1'b0;
            hex_q     <= 4'h0;
            anode_q   <= RstAnode;
            digit_q   <= 1'b0;
        end else begin
            ob_meta_q <= disp_io.onboard_sw;
            ob_sync_q <= ob_meta_q;
            bb_meta_q <= disp_io.bboard_sw;
            bb_sync_q <= bb_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            armed_q   <= 1'b1;
            hex_q     <= hex_d;
            anode_q   <= anode_d;
            digit_q   <= digit_d;
        end
    end

    assign disp_io.hex_sel      = hex_q;
    assign disp_io.anode_n      = anode_q;
    assign disp_io.active_digit = digit_q;

endmodule
